// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//  ID/EX pipeline register with load-use hazard detection, branch flush and
//  an external hold. Decoded operands, immediate, PC, control and instruction
//  fields from ID are registered into EX. The stage also drives the PC and
//  IF/ID write enables and the IF/ID flush, and counts stall and flush events.
//
// Ports
//  clk, reset           rising-edge clock, synchronous active-high reset
//  hold                 external freeze: every register keeps its value
//  branch_taken_ex      branch/jump resolved taken in EX this cycle
//  ctrl_id..inst_id     decoded instruction from ID
//  ctrl_ex..valid_ex    registered EX view (all zero = bubble)
//  inst_*_ex            opcode / rd / rs1 / rs2 for the forwarding unit
//  pc_write             comb: PC may advance
//  if_id_write          comb: IF/ID may load
//  if_id_flush          comb: IF/ID loads a NOP
//  stall_cnt, flush_cnt wrapping event counters
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int SIZE   = 32,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              branch_taken_ex,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [SIZE-1:0]   rs1_data_id,
    input  logic [SIZE-1:0]   rs2_data_id,
    input  logic [SIZE-1:0]   imm_id,
    input  logic [SIZE-1:0]   pc_id,
    input  logic [31:0]       inst_id,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [SIZE-1:0]   rs1_data_ex,
    output logic [SIZE-1:0]   rs2_data_ex,
    output logic [SIZE-1:0]   imm_ex,
    output logic [SIZE-1:0]   pc_ex,
    output logic [6:0]        inst_6_to_0_ex,
    output logic [4:0]        inst_11_to_7_ex,
    output logic [4:0]        inst_19_to_15_ex,
    output logic [4:0]        inst_24_to_20_ex,
    output logic              valid_ex,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Opcodes whose rs1 field is a real source register.
    function automatic logic uses_rs1(input logic [6:0] op);
        logic used;
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: used = 1'b1;
            default:                                             used = 1'b0;
        endcase
        return used;
    endfunction

    // Opcodes whose rs2 field is a real source register.
    function automatic logic uses_rs2(input logic [6:0] op);
        logic used;
        case (op)
            OP_R, OP_STORE, OP_BRANCH: used = 1'b1;
            default:                   used = 1'b0;
        endcase
        return used;
    endfunction

    logic load_use_s;
    logic load_s;
    logic bubble_s;
    logic stall_inc_s;
    logic flush_inc_s;

    // Load in EX whose destination is read by the instruction in ID; x0 never hazards.
    always_comb begin
        load_use_s = ctrl_ex[1] & valid_ex & (inst_11_to_7_ex != 5'd0) &
                     (((inst_11_to_7_ex == inst_id[19:15]) & uses_rs1(inst_id[6:0])) |
                      ((inst_11_to_7_ex == inst_id[24:20]) & uses_rs2(inst_id[6:0])));
    end

    // Per-cycle priority: hold, then branch flush, then load-use stall, then advance.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        load_s      = 1'b0;
        bubble_s    = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        if (hold) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken_ex) begin
            // The ID instruction is squashed, so a pending load-use is irrelevant.
            if_id_flush = 1'b1;
            bubble_s    = 1'b1;
            flush_inc_s = 1'b1;
        end else if (load_use_s) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble_s    = 1'b1;
            stall_inc_s = 1'b1;
        end else begin
            load_s = 1'b1;
        end
    end

    // ID/EX pipeline register: reset and bubble clear everything, hold keeps it.
    always_ff @(posedge clk) begin
        if (reset || bubble_s) begin
            ctrl_ex          <= '0;
            rs1_data_ex      <= '0;
            rs2_data_ex      <= '0;
            imm_ex           <= '0;
            pc_ex            <= '0;
            inst_6_to_0_ex   <= 7'd0;
            inst_11_to_7_ex  <= 5'd0;
            inst_19_to_15_ex <= 5'd0;
            inst_24_to_20_ex <= 5'd0;
            valid_ex         <= 1'b0;
        end else if (load_s) begin
            ctrl_ex          <= ctrl_id;
            rs1_data_ex      <= rs1_data_id;
            rs2_data_ex      <= rs2_data_id;
            imm_ex           <= imm_id;
            pc_ex            <= pc_id;
            inst_6_to_0_ex   <= inst_id[6:0];
            inst_11_to_7_ex  <= inst_id[11:7];
            inst_19_to_15_ex <= inst_id[19:15];
            inst_24_to_20_ex <= inst_id[24:20];
            valid_ex         <= 1'b1;
        end else begin
            ctrl_ex          <= ctrl_ex;
            rs1_data_ex      <= rs1_data_ex;
            rs2_data_ex      <= rs2_data_ex;
            imm_ex           <= imm_ex;
            pc_ex            <= pc_ex;
            inst_6_to_0_ex   <= inst_6_to_0_ex;
            inst_11_to_7_ex  <= inst_11_to_7_ex;
            inst_19_to_15_ex <= inst_19_to_15_ex;
            inst_24_to_20_ex <= inst_24_to_20_ex;
            valid_ex         <= valid_ex;
        end
    end

    // Wrapping stall/flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall_inc_s};
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, flush_inc_s};
        end
    end

endmodule
